// File: rtl/primegen_drv_pkg.sv
// -----------------------------------------------------------------------------
// primegen_drv_pkg
// Shared definitions for the prime generator driver:
//   - ST_* : FSM state encodings (IDLE, REQ, WAIT, ERR)
//   - state_e : enum built on those encodings
//   - STATE_X : all-X filler used by the FSM default branch
// -----------------------------------------------------------------------------
package primegen_drv_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_REQ  = ST_REQ,
        S_WAIT = ST_WAIT,
        S_ERR  = ST_ERR
    } state_e;

    localparam logic [1:0] STATE_X = 2'bxx;

endpackage

// File: rtl/primegen_drv_if.sv
// -----------------------------------------------------------------------------
// primegen_drv_if
// Bundles every non-clock/reset signal of primegen_drv.
//   Control : start, num (in), busy, done, err, order_err (out)
//   Gen side: gen_go (out), gen_ready, gen_error, gen_res (in)
//   Stream  : out_valid, out_data (out), out_ready (in)
// Directions are given from the driver's point of view in modport master;
// modport slave is the mirror image (host + generator + consumer).
//
// Stream handshake: a word moves on a rising clk edge where out_valid and
// out_ready are both 1; out_valid/out_data stay stable until that happens,
// and out_ready may toggle freely.
// -----------------------------------------------------------------------------
interface primegen_drv_if #(
    parameter int WIDTH_LOG = 4,
    parameter int CNT_W     = 16
);
    logic                        start;
    logic [CNT_W-1:0]            num;
    logic                        gen_go;
    logic                        gen_ready;
    logic                        gen_error;
    logic [(1<<WIDTH_LOG)-1:0]   gen_res;
    logic                        out_valid;
    logic                        out_ready;
    logic [(1<<WIDTH_LOG)-1:0]   out_data;
    logic                        busy;
    logic                        done;
    logic                        err;
    logic                        order_err;

    modport master (
        input  start, num, gen_ready, gen_error, gen_res, out_ready,
        output gen_go, out_valid, out_data, busy, done, err, order_err
    );

    modport slave (
        output start, num, gen_ready, gen_error, gen_res, out_ready,
        input  gen_go, out_valid, out_data, busy, done, err, order_err
    );
endinterface

// File: rtl/primegen_drv_prime_fifo.sv
// -----------------------------------------------------------------------------
// prime_fifo
// Synchronous first-word-fall-through FIFO for captured primes.
//   clk, rst_n : clock, synchronous active-low reset
//   i_push     : write i_wdata (ignored when full)
//   i_pop      : drop the head (ignored when empty)
//   o_full     : registered full flag
//   o_empty    : registered empty flag
//   o_head     : current head word (0 after reset)
//   o_count    : number of stored words
// Pointers carry one extra wrap bit so full and empty differ.
// -----------------------------------------------------------------------------
module prime_fifo #(
    parameter int WIDTH     = 16,
    parameter int DEPTH_LOG = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_push,
    input  logic [WIDTH-1:0]     i_wdata,
    input  logic                 i_pop,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [WIDTH-1:0]     o_head,
    output logic [DEPTH_LOG:0]   o_count
);
    localparam int                 DEPTH    = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] FULL_CNT = (DEPTH_LOG+1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [DEPTH_LOG:0] r_wr_ptr;
    logic [DEPTH_LOG:0] r_rd_ptr;
    logic               r_full;
    logic               r_empty;

    logic               w_push;
    logic               w_pop;
    logic [DEPTH_LOG:0] w_wr_nxt;
    logic [DEPTH_LOG:0] w_rd_nxt;
    logic [DEPTH_LOG:0] w_cnt_nxt;

    always_comb begin
        w_push    = i_push && !r_full;
        w_pop     = i_pop && !r_empty;
        w_wr_nxt  = r_wr_ptr + (DEPTH_LOG+1)'(w_push);
        w_rd_nxt  = r_rd_ptr + (DEPTH_LOG+1)'(w_pop);
        w_cnt_nxt = w_wr_nxt - w_rd_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) r_mem[r_wr_ptr[DEPTH_LOG-1:0]] <= i_wdata;
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            // Flags are precomputed from next pointers so they are plain flops.
            r_empty  <= (w_cnt_nxt == '0);
            r_full   <= (w_cnt_nxt == FULL_CNT);
        end
    end

    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_head  = r_mem[r_rd_ptr[DEPTH_LOG-1:0]];
    assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/primegen_drv.sv
// -----------------------------------------------------------------------------
// primegen_drv
// Drives a prime generator with one go pulse per requested prime, captures
// each result into prime_fifo and streams the primes out via valid/ready.
//   clk, rst_n  : clock, synchronous active-low reset
//   bus (master): start/num control, gen_* handshake, out_* stream,
//                 busy/done/err/order_err status
//   o_dbg_state : current FSM state (primegen_drv_pkg encoding)
// Optional feature macro: PRIMEGEN_DRV_ORDER_CHECK_EN enables the
// monotonicity check driving order_err; otherwise order_err is 0.
// -----------------------------------------------------------------------------
module primegen_drv
    import primegen_drv_pkg::*;
#(
    parameter int WIDTH_LOG = 4,
    parameter int DEPTH_LOG = 2,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    primegen_drv_if.master     bus,
    output logic [1:0]         o_dbg_state
);
    localparam int                 W     = 1 << WIDTH_LOG;
    localparam logic [DEPTH_LOG:0] DEPTH = (DEPTH_LOG+1)'(1 << DEPTH_LOG);

    state_e             r_state;
    logic [CNT_W-1:0]   r_remain;
    logic               r_bounded;
    logic               r_gen_go;
    logic               r_busy;
    logic               r_done;
    logic               r_done_pend;
    logic               r_err;

    logic               w_full;
    logic               w_empty;
    logic [W-1:0]       w_head;
    logic [DEPTH_LOG:0] w_count;
    logic [DEPTH_LOG:0] w_free;
    logic               w_capture;
    logic               w_push;
    logic               w_pop;

    // r_gen_go is high during the first WAIT cycle; the generator still shows
    // its previous ready then, so that cycle is never treated as a response.
    assign w_capture = (r_state == S_WAIT) && !r_gen_go && bus.gen_ready;
    assign w_push    = w_capture && !bus.gen_error;
    assign w_pop     = !w_empty && bus.out_ready;
    assign w_free    = DEPTH - w_count;

    prime_fifo #(
        .WIDTH     (W),
        .DEPTH_LOG (DEPTH_LOG)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata (bus.gen_res),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head),
        .o_count (w_count)
    );

`ifdef PRIMEGEN_DRV_ORDER_CHECK_EN
    logic [W-1:0] r_last;
    logic         r_order_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last      <= '0;
            r_order_err <= 1'b0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_last      <= '0;
            r_order_err <= 1'b0;
        end else if (w_push) begin
            if (bus.gen_res <= r_last) r_order_err <= 1'b1;
            r_last <= bus.gen_res;
        end
    end

    assign bus.order_err = r_order_err;
`else
    assign bus.order_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_remain    <= '0;
            r_bounded   <= 1'b0;
            r_gen_go    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_done_pend <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // A bounded run may finish its requests before the consumer drains.
            if (r_done_pend && w_empty) begin
                r_done      <= 1'b1;
                r_done_pend <= 1'b0;
            end
            if (w_push) assert (!w_full);
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_remain    <= bus.num;
                        r_bounded   <= (bus.num != '0);
                        r_err       <= 1'b0;
                        r_done_pend <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (w_free != '0) begin
                        r_gen_go <= 1'b1;
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_gen_go) begin
                        r_gen_go <= 1'b0;
                    end else if (w_capture) begin
                        if (bus.gen_error) begin
                            r_err   <= 1'b1;
                            r_state <= S_ERR;
                        end else if (r_bounded && r_remain == CNT_W'(1)) begin
                            r_remain    <= '0;
                            r_done_pend <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= S_IDLE;
                        end else begin
                            if (r_bounded) r_remain <= r_remain - CNT_W'(1);
                            r_state <= S_REQ;
                        end
                    end
                end
                S_ERR: begin
                    if (w_empty) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= state_e'(STATE_X);
            endcase
        end
    end

    assign bus.gen_go    = r_gen_go;
    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_head;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_primegen_drv.sv
// -----------------------------------------------------------------------------
// tb_primegen_drv
// Directed bench for primegen_drv with a behavioural generator attached.
// Generator modes: 0 = primes 2,3,5,...; 1 = error on third request;
// 2 = returns 7 then 5.
// -----------------------------------------------------------------------------
module tb_primegen_drv;
    import primegen_drv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    int          done_cnt;
    int          go_cnt;

    int          gen_mode;
    int          gen_lat;
    int          gen_wait;
    int          gen_cnt;
    int          gen_prime;

    primegen_drv_if #(.WIDTH_LOG(4), .CNT_W(16)) bus ();

    primegen_drv #(
        .WIDTH_LOG (4),
        .DEPTH_LOG (2),
        .CNT_W     (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.master),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- generator model ----------------
    function automatic int next_prime(int p);
        int  c;
        bit  ok;
        c  = p + 1;
        ok = 1'b0;
        while (!ok) begin
            ok = (c > 1);
            for (int d = 2; d * d <= c; d++) if (c % d == 0) ok = 1'b0;
            if (!ok) c++;
        end
        return c;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            bus.gen_ready <= 1'b1;
            bus.gen_res   <= 16'd1;
            bus.gen_error <= 1'b0;
            gen_wait      <= 0;
            gen_cnt       <= 0;
            gen_prime     <= 1;
        end else if (bus.gen_ready) begin
            if (bus.gen_go) begin
                bus.gen_ready <= 1'b0;
                bus.gen_error <= 1'b0;
                gen_wait      <= gen_lat;
            end
        end else if (gen_wait > 0) begin
            gen_wait <= gen_wait - 1;
        end else begin
            bus.gen_ready <= 1'b1;
            gen_cnt       <= gen_cnt + 1;
            if (gen_mode == 1 && gen_cnt == 2) begin
                bus.gen_error <= 1'b1;
            end else if (gen_mode == 2) begin
                bus.gen_res <= (gen_cnt == 0) ? 16'd7 : 16'd5;
            end else begin
                bus.gen_res <= 16'(next_prime(gen_prime));
                gen_prime   <= next_prime(gen_prime);
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) obs_q.push_back(bus.out_data);
        if (bus.done) done_cnt++;
        if (bus.gen_go) go_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.num       = '0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        obs_q.delete();
        exp_q.delete();
        done_cnt = 0;
        go_cnt   = 0;
    endtask

    task automatic drive_start(input logic [15:0] n);
        bus.num   = n;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
        repeat (5) tick();
    endtask

    task automatic compare_stream(input string name);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_len: got %0d expected %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s[%0d]: got %0d expected %0d", name, i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.num       = '0;
        bus.out_ready = 1'b0;
        gen_mode      = 0;
        gen_lat       = 2;
        repeat (3) tick();
        checks++; if (bus.gen_go !== 1'b0)    begin errors++; $display("FAIL rst_gen_go: got %b expected 0", bus.gen_go); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_data !== 16'd0) begin errors++; $display("FAIL rst_out_data: got %0d expected 0", bus.out_data); end
        checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0)      begin errors++; $display("FAIL rst_done: got %b expected 0", bus.done); end
        checks++; if (bus.err !== 1'b0)       begin errors++; $display("FAIL rst_err: got %b expected 0", bus.err); end
        checks++; if (bus.order_err !== 1'b0) begin errors++; $display("FAIL rst_order_err: got %b expected 0", bus.order_err); end
        checks++; if (dbg_state !== ST_IDLE)  begin errors++; $display("FAIL rst_state: got %0d expected %0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_bounded();
        do_reset();
        gen_mode = 0;
        gen_lat  = 2;
        bus.out_ready = 1'b1;
        drive_start(16'd5);
        checks++; if (bus.busy !== 1'b1)   begin errors++; $display("FAIL bnd_busy: got %b expected 1", bus.busy); end
        checks++; if (bus.gen_go !== 1'b0) begin errors++; $display("FAIL bnd_go_early: got %b expected 0", bus.gen_go); end
        tick();
        checks++; if (bus.gen_go !== 1'b1) begin errors++; $display("FAIL bnd_go_lat: got %b expected 1", bus.gen_go); end
        wait_done(400);
        exp_q = '{16'd2, 16'd3, 16'd5, 16'd7, 16'd11};
        compare_stream("bnd_data");
        checks++; if (done_cnt != 1)     begin errors++; $display("FAIL bnd_done_cnt: got %0d expected 1", done_cnt); end
        checks++; if (go_cnt != 5)       begin errors++; $display("FAIL bnd_go_cnt: got %0d expected 5", go_cnt); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bnd_busy_end: got %b expected 0", bus.busy); end
    endtask

    task automatic test_backpressure();
        int n;
        do_reset();
        gen_mode = 0;
        gen_lat  = 1;
        drive_start(16'd0);
        repeat (80) tick();
        checks++; if (go_cnt != 4)            begin errors++; $display("FAIL bp_go_cnt: got %0d expected 4", go_cnt); end
        checks++; if (bus.out_data !== 16'd2) begin errors++; $display("FAIL bp_head: got %0d expected 2", bus.out_data); end
        checks++; if (dbg_state !== ST_REQ)   begin errors++; $display("FAIL bp_state: got %0d expected %0d", dbg_state, ST_REQ); end
        repeat (30) tick();
        checks++; if (go_cnt != 4)            begin errors++; $display("FAIL bp_go_hold: got %0d expected 4", go_cnt); end
        bus.out_ready = 1'b1;
        n = 0;
        while (obs_q.size() < 8 && n < 400) begin
            tick();
            n++;
        end
        bus.out_ready = 1'b0;
        exp_q = '{16'd2, 16'd3, 16'd5, 16'd7, 16'd11, 16'd13, 16'd17, 16'd19};
        while (obs_q.size() > 8) void'(obs_q.pop_back());
        compare_stream("bp_data");
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL bp_done: got %0d expected 0", done_cnt); end
    endtask

    task automatic test_error();
        int n;
        do_reset();
        gen_mode = 1;
        gen_lat  = 2;
        drive_start(16'd0);
        n = 0;
        while (dbg_state != ST_ERR && n < 300) begin
            tick();
            n++;
        end
        repeat (20) tick();
        checks++; if (bus.err !== 1'b1)  begin errors++; $display("FAIL err_flag: got %b expected 1", bus.err); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL err_busy_hold: got %b expected 1", bus.busy); end
        checks++; if (go_cnt != 3)       begin errors++; $display("FAIL err_go_cnt: got %0d expected 3", go_cnt); end
        bus.out_ready = 1'b1;
        repeat (10) tick();
        exp_q = '{16'd2, 16'd3};
        compare_stream("err_data");
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL err_busy_end: got %b expected 0", bus.busy); end
        checks++; if (bus.err !== 1'b1)  begin errors++; $display("FAIL err_sticky: got %b expected 1", bus.err); end
        gen_mode = 0;
        obs_q.delete();
        done_cnt = 0;
        drive_start(16'd1);
        checks++; if (bus.err !== 1'b0)  begin errors++; $display("FAIL err_clear: got %b expected 0", bus.err); end
        wait_done(200);
        exp_q = '{16'd5};
        compare_stream("err_restart");
    endtask

    task automatic test_reset_mid_wait();
        int n;
        do_reset();
        gen_mode = 0;
        gen_lat  = 6;
        bus.out_ready = 1'b1;
        drive_start(16'd3);
        n = 0;
        while (!(dbg_state == ST_WAIT && !bus.gen_go) && n < 50) begin
            tick();
            n++;
        end
        checks++; if (dbg_state !== ST_WAIT) begin errors++; $display("FAIL rmw_in_wait: got %0d expected %0d", dbg_state, ST_WAIT); end
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rmw_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL rmw_busy: got %b expected 0", bus.busy); end
        checks++; if (bus.gen_go !== 1'b0)    begin errors++; $display("FAIL rmw_gen_go: got %b expected 0", bus.gen_go); end
        checks++; if (dbg_state !== ST_IDLE)  begin errors++; $display("FAIL rmw_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        rst_n = 1'b1;
        tick();
        obs_q.delete();
        done_cnt = 0;
        gen_lat  = 2;
        drive_start(16'd1);
        wait_done(200);
        exp_q = '{16'd2};
        compare_stream("rmw_restart");
    endtask

    task automatic test_order();
        logic exp_oe;
`ifdef PRIMEGEN_DRV_ORDER_CHECK_EN
        exp_oe = 1'b1;
`else
        exp_oe = 1'b0;
`endif
        do_reset();
        gen_mode = 2;
        gen_lat  = 1;
        bus.out_ready = 1'b1;
        drive_start(16'd2);
        wait_done(200);
        exp_q = '{16'd7, 16'd5};
        compare_stream("ord_data");
        checks++; if (bus.order_err !== exp_oe) begin errors++; $display("FAIL ord_flag: got %b expected %b", bus.order_err, exp_oe); end
    endtask

    task automatic test_start_ignored();
        do_reset();
        gen_mode = 0;
        gen_lat  = 3;
        bus.out_ready = 1'b1;
        drive_start(16'd3);
        for (int i = 0; i < 4; i++) begin
            bus.num   = 16'd9;
            bus.start = 1'b1;
            tick();
            bus.start = 1'b0;
            tick();
        end
        wait_done(300);
        repeat (20) tick();
        exp_q = '{16'd2, 16'd3, 16'd5};
        compare_stream("ign_data");
        checks++; if (go_cnt != 3)   begin errors++; $display("FAIL ign_go_cnt: got %0d expected 3", go_cnt); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL ign_done_cnt: got %0d expected 1", done_cnt); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        done_cnt = 0;
        go_cnt   = 0;
        test_reset();
        test_bounded();
        test_backpressure();
        test_error();
        test_reset_mid_wait();
        test_order();
        test_start_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
